video_timing_measure: RTL and testbench

- Upstream stage of the display fail-safe checker: measures incoming video timing from DE/VSYNC and produces the per-line active width and per-frame active line count that the checker consumes.
- Also flags lines of differing width within a frame, loss of signal (no VSYNC), and multi-frame timing stability.
- Zeroed outputs during no-signal keep the downstream checker parked in its idle state.

---
 rtl/video_timing_measure_if.sv | 21 ++
 rtl/video_timing_measure.sv | 96 +++++++++
 tb/tb_video_timing_measure.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/video_timing_measure_if.sv
// video_timing_measure_if: video timing input (de, vsync) and measurement result bundle
// master: video source / result consumer (drives de, vsync; reads results)
// slave : video_timing_measure (reads de, vsync; drives results)
interface video_timing_measure_if;
    logic        de;
    logic        vsync;
    logic [11:0] active_width;
    logic [10:0] line_num;
    logic        frame_done;
    logic        width_varies;
    logic        stable;
    logic        no_signal;
    modport master (
        output de, vsync,
        input  active_width, line_num, frame_done, width_varies, stable, no_signal
    );
    modport slave (
        input  de, vsync,
        output active_width, line_num, frame_done, width_varies, stable, no_signal
    );
endinterface

// File: rtl/video_timing_measure.sv
// video_timing_measure: measures per-line active width and per-frame line count from DE/VSYNC
// Ports:
//   clock  - pixel clock
//   reset  - synchronous active-high reset
//   video  - slave side of video_timing_measure_if:
//            de, vsync in; active_width, line_num, frame_done, width_varies, stable, no_signal out
module video_timing_measure #(
    parameter logic        VSYNC_POL      = 1'b1,
    parameter logic [2:0]  STABLE_FRAMES  = 3'd2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd3000000
) (
    input logic                   clock,
    input logic                   reset,
    video_timing_measure_if.slave video
);
    typedef enum logic [1:0] {SEARCH, MEASURE, NO_SIGNAL} state_t;
    state_t      state, state_n;
    logic        de_r, de_rr, vs_r, vs_rr;
    logic [23:0] tmo_cnt;
    logic [11:0] width_cnt, ref_width, prev_width, active_width, aw_n;
    logic [10:0] line_cnt, line_num, lc_n;
    logic [2:0]  match_cnt;
    logic        var_acc, var_n, width_varies, frame_done;
    logic        de_fall, vs_edge, tmo_hit, meas, cap, close, match;
    assign de_fall = de_rr & ~de_r;
    assign vs_edge = (vs_r == VSYNC_POL) && (vs_rr != VSYNC_POL);
    assign tmo_hit = tmo_cnt == TIMEOUT_CYCLES;
    assign meas    = state == MEASURE;
    assign cap     = meas && de_fall;
    assign close   = meas && vs_edge;
    // Values including a line that ends in this very cycle, so a DE fall
    // coincident with the frame boundary still belongs to the closing frame.
    assign lc_n  = (cap && line_cnt != 11'd2047) ? line_cnt + 11'd1 : line_cnt;
    assign aw_n  = cap ? width_cnt : active_width;
    assign var_n = var_acc | (cap && line_cnt != 11'd0 && width_cnt != ref_width);
    assign match = (lc_n == line_num) && (aw_n == prev_width) && !var_n && (lc_n != 11'd0);
    // A frame boundary always wins: it is the only way out of NO_SIGNAL,
    // where the saturated timeout counter keeps tmo_hit asserted.
    always_comb begin
        state_n = state;
        state_n = vs_edge ? MEASURE : (tmo_hit ? NO_SIGNAL : state);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= SEARCH;
            de_r         <= 1'b0;
            de_rr        <= 1'b0;
            vs_r         <= 1'b0;
            vs_rr        <= 1'b0;
            tmo_cnt      <= '0;
            width_cnt    <= '0;
            line_cnt     <= '0;
            var_acc      <= 1'b0;
            ref_width    <= '0;
            frame_done   <= 1'b0;
            active_width <= '0;
            line_num     <= '0;
            width_varies <= 1'b0;
            prev_width   <= '0;
            match_cnt    <= '0;
        end else begin
            state      <= state_n;
            de_r       <= video.de;
            de_rr      <= de_r;
            vs_r       <= video.vsync;
            vs_rr      <= vs_r;
            tmo_cnt    <= vs_edge ? '0 : (tmo_hit ? tmo_cnt : tmo_cnt + 24'd1);
            width_cnt  <= (!meas || de_fall) ? '0 : ((de_r && width_cnt != 12'd4095) ? width_cnt + 12'd1 : width_cnt);
            line_cnt   <= vs_edge ? '0 : lc_n;
            var_acc    <= vs_edge ? 1'b0 : var_n;
            ref_width  <= vs_edge ? '0 : ((cap && line_cnt == 11'd0) ? width_cnt : ref_width);
            frame_done <= close;
            if (state_n == NO_SIGNAL) begin
                active_width <= '0;
                line_num     <= '0;
                width_varies <= 1'b0;
                prev_width   <= '0;
                match_cnt    <= '0;
            end else begin
                active_width <= aw_n;
                if (close) begin
                    line_num     <= lc_n;
                    width_varies <= var_n;
                    prev_width   <= aw_n;
                    match_cnt    <= !match ? 3'd0 : ((match_cnt == STABLE_FRAMES) ? match_cnt : match_cnt + 3'd1);
                end
            end
        end
    end
    assign video.active_width = active_width;
    assign video.line_num     = line_num;
    assign video.frame_done   = frame_done;
    assign video.width_varies = width_varies;
    assign video.stable       = match_cnt == STABLE_FRAMES;
    assign video.no_signal    = state == NO_SIGNAL;
endmodule

// File: tb/tb_video_timing_measure.sv
// tb_video_timing_measure: randomized frame stimulus checked against a frame-level reference model
module tb_video_timing_measure;
    localparam int STB = 2;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    video_timing_measure_if vif();
    video_timing_measure #(
        .VSYNC_POL(1'b1),
        .STABLE_FRAMES(3'd2),
        .TIMEOUT_CYCLES(24'd9000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .video(vif)
    );
    always #5 clock = ~clock;
    bit meas;
    int cur[$];
    int m_ln, m_aw, m_prevw, m_mc;
    bit m_wv;
    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic model_clear();
        meas = 1'b0;
        cur.delete();
        m_ln = 0;
        m_aw = 0;
        m_prevw = 0;
        m_mc = 0;
        m_wv = 1'b0;
    endtask
    task automatic close_model(output bit cl);
        int n, nl;
        bit v, mt;
        cl = meas;
        if (meas) begin
            n = cur.size();
            nl = sat(n, 2047);
            v = 1'b0;
            foreach (cur[i]) if (sat(cur[i], 4095) != sat(cur[0], 4095)) v = 1'b1;
            mt = (nl == m_ln) && (m_aw == m_prevw) && !v && (n != 0);
            m_mc = mt ? sat(m_mc + 1, STB) : 0;
            m_ln = nl;
            m_wv = v;
            m_prevw = m_aw;
        end
        meas = 1'b1;
        cur.delete();
    endtask
    task automatic check_quiet(input string tag, input int ns);
        check({tag, "_active_width"}, vif.active_width, 0);
        check({tag, "_line_num"}, vif.line_num, 0);
        check({tag, "_frame_done"}, vif.frame_done, 0);
        check({tag, "_width_varies"}, vif.width_varies, 0);
        check({tag, "_stable"}, vif.stable, 0);
        check({tag, "_no_signal"}, vif.no_signal, ns);
    endtask
    task automatic send_lines(input int n, input int w, input int odd_idx, input int odd_w, input int blank, input bit coinc);
        for (int i = 0; i < n; i++) begin
            int wi;
            wi = (i == odd_idx) ? odd_w : w;
            vif.de = 1'b1;
            repeat (wi) @(negedge clock);
            vif.de = 1'b0;
            if (meas) begin
                cur.push_back(wi);
                m_aw = sat(wi, 4095);
            end
            if (!(coinc && i == n - 1)) repeat (blank) @(negedge clock);
        end
    endtask
    task automatic frame_edge();
        bit cl;
        int pulses;
        close_model(cl);
        pulses = 0;
        vif.vsync = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (i == 3) vif.vsync = 1'b0;
            if (vif.frame_done) pulses++;
        end
        check("frame_done_pulses", pulses, cl ? 1 : 0);
        if (cl) begin
            check("line_num", vif.line_num, m_ln);
            check("active_width", vif.active_width, m_aw);
            check("width_varies", vif.width_varies, m_wv);
            check("stable", vif.stable, m_mc == STB);
        end
        check("no_signal_clear", vif.no_signal, 0);
    endtask
    task automatic frame(input int n, input int w, input int odd_idx, input int odd_w, input bit coinc);
        send_lines(n, w, odd_idx, odd_w, 4, coinc);
        frame_edge();
    endtask
    initial begin
        int n, w, oi, waited;
        vif.de = 1'b0;
        vif.vsync = 1'b0;
        reset = 1'b1;
        model_clear();
        repeat (3) @(negedge clock);
        check_quiet("reset", 0);
        reset = 1'b0;
        n = $urandom_range(32, 16);
        w = $urandom_range(24, 8);
        send_lines(10, w, -1, 0, 4, 1'b0);
        frame_edge();
        repeat (5) frame(n, w, -1, 0, 1'b0);
        frame(n, w, $urandom_range(n - 2, 1), w - 1, 1'b0);
        repeat (3) frame(n, w, -1, 0, 1'b0);
        repeat (2) frame(n, w, -1, 0, 1'b1);
        frame(1, 5000, -1, 0, 1'b0);
        send_lines(2100, 1, -1, 0, 2, 1'b0);
        frame_edge();
        frame(n, w, -1, 0, 1'b0);
        repeat (4) begin
            n = $urandom_range(32, 16);
            w = $urandom_range(24, 8);
            oi = -1;
            if ($urandom_range(1, 0) == 1) oi = $urandom_range(n - 1, 0);
            frame(n, w, oi, $urandom_range(24, 8), 1'b0);
        end
        frame(n, w, -1, 0, 1'b0);
        send_lines(20, w, -1, 0, 4, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check_quiet("mid_reset", 0);
        reset = 1'b0;
        model_clear();
        send_lines(12, w, -1, 0, 4, 1'b0);
        frame_edge();
        frame(n, w, -1, 0, 1'b0);
        send_lines(5, w + 3, -1, 0, 4, 1'b0);
        check("width_without_vsync", vif.active_width, m_aw);
        check("no_signal_early", vif.no_signal, 0);
        waited = 0;
        while (!vif.no_signal && waited < 12000) begin
            @(negedge clock);
            waited++;
        end
        model_clear();
        check_quiet("lost", 1);
        frame_edge();
        repeat (3) frame(n, w, -1, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
